// File: rtl/pipeline_pkg.sv
// Shared state encodings and defaults for the pipeline sequencer and its helpers.
package pipeline_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int DRAIN_CYC_DEF = 4;

  // States in which the pipeline registers are allowed to advance.
  function automatic logic is_adv(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_STEP) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the sources read in ID.
module hazard_detect #(
  parameter int REG_SZ = 5
) (
  input  logic              i_ex_mem_read,
  input  logic [REG_SZ-1:0] i_ex_rt,
  input  logic [REG_SZ-1:0] i_id_rs,
  input  logic [REG_SZ-1:0] i_id_rt,
  output logic              o_load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign o_load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Debug-controlled run/step/halt sequencer for a five-stage pipeline, with
// load-use stall generation and a saturating retired-cycle counter.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int REG_SZ    = 5,
  parameter int CNT_SZ    = 32,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic              i_halt_inst,
  input  logic              i_ex_mem_read,
  input  logic [REG_SZ-1:0] i_ex_rt,
  input  logic [REG_SZ-1:0] i_id_rs,
  input  logic [REG_SZ-1:0] i_id_rt,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_pipe_en,
  output logic [2:0]        o_state,
  output logic              o_halted,
  output logic [CNT_SZ-1:0] o_cycle_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

  logic [2:0]        state_reg, state_next;
  logic [DW-1:0]     drain_cnt_reg, drain_cnt_next;
  logic [CNT_SZ-1:0] cycle_cnt_reg;
  logic              halted_reg;
  logic              load_use;
  logic              adv;
  logic              halt_go;

  hazard_detect #(.REG_SZ(REG_SZ)) u_hazard (
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt       (i_ex_rt),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .o_load_use    (load_use)
  );

  assign adv     = is_adv(state_reg);
  // A stalled HALT has not really been decoded yet; it retries next cycle.
  assign halt_go = i_halt_inst && !load_use;

  assign o_pipe_en     = adv;
  assign o_pc_write    = adv && !load_use && (state_reg != ST_DRAIN);
  assign o_if_id_write = o_pc_write;
  assign o_id_ex_flush = adv && load_use;
  assign o_if_id_flush = adv && ((state_reg == ST_DRAIN) ||
                                 (halt_go && (state_reg != ST_DRAIN)));

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_run)       state_next = ST_RUN;
        else if (i_step) state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt_go) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (i_halt_req) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_go) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == '0) state_next = ST_HALTED;
        else                     drain_cnt_next = drain_cnt_reg - DW'(1);
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= '0;
      cycle_cnt_reg <= '0;
      halted_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      halted_reg    <= (state_next == ST_HALTED);
      if (adv && !(&cycle_cnt_reg))
        cycle_cnt_reg <= cycle_cnt_reg + CNT_SZ'(1);
    end
  end

  assign o_state     = state_reg;
  assign o_halted    = halted_reg;
  assign o_cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a default instance plus a 4-bit counter instance.
module tb_pipeline_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 0, step = 0, halt_req = 0, halt_inst = 0, ex_mem_read = 0;
  logic [4:0]  ex_rt = 0, id_rs = 0, id_rt = 0;

  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en, halted;
  logic [2:0]  state;
  logic [31:0] cnt;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_en, s_halted;
  logic [2:0]  s_state;
  logic [3:0]  s_cnt;
  logic [4:0]  ctrl, s_ctrl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // ctrl bit order: pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en
  assign ctrl   = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en};
  assign s_ctrl = {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_en};

  pipeline_sequencer dut (
    .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_step(step), .i_halt_req(halt_req),
    .i_halt_inst(halt_inst), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush), .o_pipe_en(pipe_en),
    .o_state(state), .o_halted(halted), .o_cycle_cnt(cnt)
  );

  pipeline_sequencer #(.CNT_SZ(4)) dut_sat (
    .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_step(step), .i_halt_req(halt_req),
    .i_halt_inst(halt_inst), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .o_pc_write(s_pc_write), .o_if_id_write(s_if_id_write),
    .o_if_id_flush(s_if_id_flush), .o_id_ex_flush(s_id_ex_flush), .o_pipe_en(s_pipe_en),
    .o_state(s_state), .o_halted(s_halted), .o_cycle_cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (ctrl !== 5'b00000 || s_ctrl !== 5'b00000) begin
        bad++;
        $display("FAIL reset_ctrl cyc=%0d got=%b/%b want=00000", i, ctrl, s_ctrl);
      end
      total++;
      if (state !== S_IDLE || s_state !== S_IDLE || halted !== 1'b0 || s_halted !== 1'b0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%0d/%0d halted=%b/%b want=0 halted=0",
                 i, state, s_state, halted, s_halted);
      end
      total++;
      if (cnt !== 32'd0 || s_cnt !== 4'd0) begin
        bad++;
        $display("FAIL reset_cnt cyc=%0d got=%0d/%0d want=0", i, cnt, s_cnt);
      end
    end
    $display("test_reset: 10 idle cycles checked");
  endtask

  task automatic test_step();
    step = 1'b1;
    #1;
    total++;
    if (ctrl !== 5'b00000) begin
      bad++; $display("FAIL step_pre_ctrl got=%b want=00000", ctrl);
    end
    tick();
    step = 1'b0;
    #1;
    total++;
    if (state !== S_STEP || ctrl !== 5'b11001) begin
      bad++; $display("FAIL step_active got state=%0d ctrl=%b want state=2 ctrl=11001", state, ctrl);
    end
    tick();
    total++;
    if (state !== S_IDLE || ctrl !== 5'b00000 || cnt !== 32'd1) begin
      bad++;
      $display("FAIL step_done got state=%0d ctrl=%b cnt=%0d want state=0 ctrl=00000 cnt=1",
               state, ctrl, cnt);
    end
    // stalled step still consumes the step
    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd0; id_rt = 5'd3; step = 1'b1;
    tick();
    step = 1'b0;
    #1;
    total++;
    if (state !== S_STEP || ctrl !== 5'b00011) begin
      bad++; $display("FAIL step_stall got state=%0d ctrl=%b want state=2 ctrl=00011", state, ctrl);
    end
    tick();
    total++;
    if (state !== S_IDLE || cnt !== 32'd2) begin
      bad++; $display("FAIL step_stall_done got state=%0d cnt=%0d want state=0 cnt=2", state, cnt);
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    $display("test_step: plain and stalled step checked");
  endtask

  task automatic test_load_use();
    // {mem_read, ex_rt, id_rs, id_rt, expected ctrl}
    logic [20:0] vec [5];
    vec[0] = {1'b1, 5'd5, 5'd5, 5'd0, 5'b00011};
    vec[1] = {1'b1, 5'd0, 5'd0, 5'd0, 5'b11001};
    vec[2] = {1'b1, 5'd7, 5'd2, 5'd7, 5'b00011};
    vec[3] = {1'b0, 5'd5, 5'd5, 5'd5, 5'b11001};
    vec[4] = {1'b1, 5'd6, 5'd5, 5'd7, 5'b11001};
    run = 1'b1;
    tick();
    run = 1'b0;
    total++;
    if (state !== S_RUN || cnt !== 32'd2) begin
      bad++; $display("FAIL run_enter got state=%0d cnt=%0d want state=1 cnt=2", state, cnt);
    end
    for (int i = 0; i < 5; i++) begin
      {ex_mem_read, ex_rt, id_rs, id_rt} = vec[i][20:5];
      #1;
      total++;
      if (ctrl !== vec[i][4:0]) begin
        bad++;
        $display("FAIL load_use vec=%0d got ctrl=%b want ctrl=%b", i, ctrl, vec[i][4:0]);
      end
      $display("load_use vec=%0d rd=%b ex_rt=%0d rs=%0d rt=%0d ctrl=%b",
               i, ex_mem_read, ex_rt, id_rs, id_rt, ctrl);
      tick();
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    step = 1'b1;
    tick();
    step = 1'b0;
    total++;
    if (state !== S_RUN || cnt !== 32'd8) begin
      bad++; $display("FAIL run_step_ignored got state=%0d cnt=%0d want state=1 cnt=8", state, cnt);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++;
    if (state !== S_IDLE || cnt !== 32'd9) begin
      bad++; $display("FAIL run_halt_req got state=%0d cnt=%0d want state=0 cnt=9", state, cnt);
    end
  endtask

  task automatic test_halt();
    halt_inst = 1'b1;
    #1;
    total++;
    if (ctrl !== 5'b00000) begin
      bad++; $display("FAIL halt_idle_ctrl got=%b want=00000", ctrl);
    end
    tick();
    halt_inst = 1'b0;
    total++;
    if (state !== S_IDLE) begin
      bad++; $display("FAIL halt_idle_state got=%0d want=0", state);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    // HALT behind a load-use stall must wait
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; halt_inst = 1'b1;
    #1;
    total++;
    if (ctrl !== 5'b00011) begin
      bad++; $display("FAIL halt_stalled_ctrl got=%b want=00011", ctrl);
    end
    tick();
    total++;
    if (state !== S_RUN || cnt !== 32'd10) begin
      bad++; $display("FAIL halt_stalled_state got state=%0d cnt=%0d want state=1 cnt=10", state, cnt);
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    total++;
    if (ctrl !== 5'b11101) begin
      bad++; $display("FAIL halt_decode_ctrl got=%b want=11101", ctrl);
    end
    tick();
    halt_inst = 1'b0;
    run = 1'b1; step = 1'b1; halt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state !== S_DRAIN || ctrl !== 5'b00101 || halted !== 1'b0) begin
        bad++;
        $display("FAIL drain cyc=%0d got state=%0d ctrl=%b halted=%b want state=3 ctrl=00101 halted=0",
                 i, state, ctrl, halted);
      end
      $display("drain cyc=%0d state=%0d ctrl=%b", i, state, ctrl);
      @(posedge clk);
    end
    #1;
    total++;
    if (state !== S_HALTED || halted !== 1'b1 || ctrl !== 5'b00000 || cnt !== 32'd15) begin
      bad++;
      $display("FAIL halted got state=%0d halted=%b ctrl=%b cnt=%0d want state=4 halted=1 ctrl=00000 cnt=15",
               state, halted, ctrl, cnt);
    end
    tick();
    tick();
    total++;
    if (state !== S_HALTED || halted !== 1'b1 || cnt !== 32'd15) begin
      bad++;
      $display("FAIL halted_sticky got state=%0d halted=%b cnt=%0d want state=4 halted=1 cnt=15",
               state, halted, cnt);
    end
    run = 1'b0; step = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_priority();
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== S_IDLE || halted !== 1'b0 || cnt !== 32'd0 || ctrl !== 5'b00000) begin
      bad++;
      $display("FAIL async_reset got state=%0d halted=%b cnt=%0d ctrl=%b want 0/0/0/00000",
               state, halted, cnt, ctrl);
    end
    tick();
    rst_n = 1'b1;
    run = 1'b1; step = 1'b1;
    tick();
    run = 1'b0; step = 1'b0;
    total++;
    if (state !== S_RUN) begin
      bad++; $display("FAIL run_and_step got state=%0d want=1", state);
    end
    halt_inst = 1'b1; halt_req = 1'b1;
    tick();
    halt_inst = 1'b0; halt_req = 1'b0;
    total++;
    if (state !== S_DRAIN || cnt !== 32'd1) begin
      bad++; $display("FAIL halt_beats_req got state=%0d cnt=%0d want state=3 cnt=1", state, cnt);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (state !== S_IDLE || cnt !== 32'd0 || s_cnt !== 4'd0 || ctrl !== 5'b00000) begin
      bad++;
      $display("FAIL reset_mid_drain got state=%0d cnt=%0d/%0d ctrl=%b want state=0 cnt=0 ctrl=00000",
               state, cnt, s_cnt, ctrl);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (state !== S_IDLE || cnt !== 32'd0) begin
      bad++; $display("FAIL after_drain_reset got state=%0d cnt=%0d want state=0 cnt=0", state, cnt);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (state !== S_IDLE || ctrl !== 5'b00000) begin
      bad++; $display("FAIL reset_mid_step got state=%0d ctrl=%b want state=0 ctrl=00000", state, ctrl);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (state !== S_IDLE || cnt !== 32'd0) begin
      bad++; $display("FAIL after_step_reset got state=%0d cnt=%0d want state=0 cnt=0", state, cnt);
    end
    $display("test_priority: command priority and async reset checked");
  endtask

  task automatic test_saturate();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (14) tick();
    total++;
    if (s_cnt !== 4'd14 || cnt !== 32'd14) begin
      bad++; $display("FAIL sat_pre got=%0d/%0d want=14/14", s_cnt, cnt);
    end
    repeat (6) tick();
    total++;
    if (s_cnt !== 4'd15 || cnt !== 32'd20 || s_ctrl !== 5'b11001) begin
      bad++;
      $display("FAIL sat_hold got=%0d/%0d ctrl=%b want=15/20 ctrl=11001", s_cnt, cnt, s_ctrl);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++;
    if (s_cnt !== 4'd15 || cnt !== 32'd21 || s_state !== S_IDLE) begin
      bad++;
      $display("FAIL sat_stop got=%0d/%0d state=%0d want=15/21 state=0", s_cnt, cnt, s_state);
    end
    $display("test_saturate: small=%0d wide=%0d", s_cnt, cnt);
  endtask

  initial begin
    test_reset();
    test_step();
    test_load_use();
    test_halt();
    test_priority();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter REG_SZ, default 5: register-address width.
REQ-002 Parameter CNT_SZ, default 32: retired-cycle counter width.
REQ-003 Parameter DRAIN_CYC, default 4: cycles allowed for the pipeline to drain after HALT.
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_run / i_step / i_halt_req  input  1 each  debug-unit command pulses: continuous run, single step, stop.
REQ-007 i_halt_inst  input  1  HALT opcode decoded in ID.
REQ-008 i_ex_mem_read  input  1  instruction in EX is a load.
REQ-009 i_ex_rt, i_id_rs, i_id_rt  input  REG_SZ each  EX load destination; ID source registers.
REQ-010 o_pc_write  output  1  PC write enable.
REQ-011 o_if_id_write  output  1  IF/ID enable; low = hold.
REQ-012 o_if_id_flush  output  1  IF/ID loads NOP (0).
REQ-013 o_id_ex_flush  output  1  ID/EX loads bubble.
REQ-014 o_pipe_en  output  1  enable for ID/EX, EX/MEM, MEM/WB.
REQ-015 o_state  output  3  current FSM state encoding.
REQ-016 o_halted  output  1  high only in HALTED.
REQ-017 o_cycle_cnt  output  CNT_SZ  count of advanced cycles.

Function
REQ-018 States: IDLE, RUN, STEP, DRAIN, HALTED; adv = state in {RUN, STEP, DRAIN}.
REQ-019 load_use = i_ex_mem_read and i_ex_rt != 0 and (i_ex_rt == i_id_rs or i_ex_rt == i_id_rt); combinational.
REQ-020 o_pipe_en = adv.
REQ-021 o_pc_write = o_if_id_write = adv and not load_use and state != DRAIN.
REQ-022 o_id_ex_flush = adv and load_use.
REQ-023 o_if_id_flush = adv and (state == DRAIN or (i_halt_inst and not load_use)).
REQ-024 All control outputs combinational from state and hazard inputs, zero latency; o_state, o_halted, o_cycle_cnt registered.
REQ-025 IDLE: i_run -> RUN; i_step (without i_run) -> STEP; i_run and i_step together -> RUN; else hold.
REQ-026 RUN: i_halt_inst and not load_use -> DRAIN; else i_halt_req -> IDLE; else stay; HALT wins over i_halt_req.
REQ-027 STEP: lasts exactly one cycle; i_halt_inst and not load_use -> DRAIN, else -> IDLE; a stalled step (load_use) still consumes the step.
REQ-028 DRAIN: counter loaded with DRAIN_CYC-1 on entry, decrements each cycle; at 0 -> HALTED; i_run, i_step, i_halt_req ignored.
REQ-029 HALTED: terminal until reset; all control outputs 0; commands ignored.
REQ-030 i_halt_inst ignored outside RUN/STEP; i_step in RUN ignored.
REQ-031 o_cycle_cnt increments by 1 each adv cycle; saturates at all-ones, no wrap.

Reset
REQ-032 i_reset low asynchronously forces IDLE, drain counter 0, o_cycle_cnt 0, o_halted 0; therefore all control outputs 0.
REQ-033 Reset asserted mid-DRAIN or mid-STEP aborts with no further advance; release resumes in IDLE.

Structure
REQ-034 State encodings and default DRAIN_CYC in shared package pipeline_pkg.
REQ-035 Load-use comparison in sub-module hazard_detect (purely combinational); FSM and counters in pipeline_sequencer.

Verification
REQ-036 Reset release, no commands for 10 cycles -> all control outputs 0, o_state IDLE, o_cycle_cnt 0.
REQ-037 i_step pulse with no hazard -> exactly one cycle with o_pc_write = o_if_id_write = o_pipe_en = 1, back to IDLE, o_cycle_cnt 1.
REQ-038 RUN, i_ex_mem_read=1, i_ex_rt=5, i_id_rs=5 -> o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1, o_pipe_en=1; same with i_ex_rt=0 -> no stall.
REQ-039 RUN, i_halt_inst=1 -> o_if_id_flush=1, PC frozen, 4 DRAIN cycles with o_pipe_en=1, then HALTED, o_halted=1; later i_run ignored.
REQ-040 RUN with i_halt_inst and i_halt_req in same cycle -> DRAIN; i_run and i_step together in IDLE -> RUN.
REQ-041 CNT_SZ=4, RUN 20 cycles -> o_cycle_cnt saturates at 15; i_reset low mid-DRAIN -> immediate IDLE, counter 0.
